mult32x32_arbiter: RTL and testbench

Shares one `mult32x32` multiplier between `N_REQ` requesters. It uses round-robin arbitration, a per-requester request/grant/done handshake and a registered result. The block sits between client blocks and a `mult32x32` instance owned by the parent. It sequences the multiplier's `start`/`busy` protocol so clients never touch it directly.

---
 rtl/mult_arb_pkg.sv | 24 ++
 rtl/rr_picker.sv | 33 +++
 rtl/mult32x32_arbiter.sv | 136 +++++++++++++
 tb/tb_mult32x32_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the mult32x32 arbiter and its round-robin picker.
//   state_t   : arbiter FSM states
//   OP_W      : multiplier operand width
//   PROD_W    : multiplier product width
//   idx_width : bits needed to index n requesters (at least 1)
package mult_arb_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        ARM     = 3'd2,
        RUN     = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req   in  N  : (masked) request vector
//   ptr   in  IW : highest-priority index for this pick
//   valid out 1  : at least one request set
//   idx   out IW : first set bit at or after ptr, wrapping modulo N
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Shares one parent-owned mult32x32 between N_REQ requesters with
// round-robin arbitration and a request/grant/done handshake.
//   clk, reset          : clock; asynchronous active-low reset
//   req/req_a/req_b     : per-requester level request and operands
//   grant/done          : one-hot single-cycle pulses (capture / result valid)
//   result              : registered product, held until the next capture
//   err                 : sticky arm-timeout flag
//   mult_start/a/b      : to multiplier (registered)
//   mult_busy/product   : from multiplier
module mult32x32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ARM_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0][OP_W-1:0] req_a,
    input  logic [N_REQ-1:0][OP_W-1:0] req_b,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [PROD_W-1:0]          result,
    output logic                       err,
    output logic                       mult_start,
    output logic [OP_W-1:0]            mult_a,
    output logic [OP_W-1:0]            mult_b,
    input  logic                       mult_busy,
    input  logic [PROD_W-1:0]          mult_product
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned CW = $clog2(ARM_TIMEOUT + 1);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    arm_cnt;
    logic [CW-1:0]    arm_nxt;
    logic             mask_last;
    logic [N_REQ-1:0] req_m;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    // The requester just served may still show req in the first IDLE
    // cycle after DONE; hide it for that one cycle only.
    always_comb begin
        req_m = req;
        if (mask_last) begin
            req_m[idx] = 1'b0;
        end
    end

    assign arm_nxt = arm_cnt + 1'b1;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_m),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            arm_cnt    <= '0;
            mask_last  <= 1'b0;
            grant      <= '0;
            done       <= '0;
            result     <= '0;
            err        <= 1'b0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
        end else begin
            grant      <= '0;
            done       <= '0;
            mult_start <= 1'b0;
            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (pick_valid) begin
                        idx    <= pick_idx;
                        mult_a <= req_a[pick_idx];
                        mult_b <= req_b[pick_idx];
                        grant  <= N_REQ'(1) << pick_idx;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    mult_start <= 1'b1;
                    arm_cnt    <= '0;
                    state      <= ARM;
                end
                ARM: begin
                    if (mult_busy) begin
                        arm_cnt <= '0;
                        state   <= RUN;
                    end else if (arm_nxt == CW'(ARM_TIMEOUT)) begin
                        // Multiplier never armed: release the requester
                        // with a zero result; pointer is left unchanged.
                        arm_cnt <= '0;
                        err     <= 1'b1;
                        done    <= N_REQ'(1) << idx;
                        result  <= '0;
                        state   <= IDLE;
                    end else begin
                        arm_cnt <= arm_nxt;
                    end
                end
                RUN: begin
                    if (!mult_busy) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result <= mult_product;
                    done   <= N_REQ'(1) << idx;
                    state  <= DONE;
                end
                DONE: begin
                    ptr       <= IW'((32'(idx) + 1) % N_REQ);
                    mask_last <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Self-checking bench for mult32x32_arbiter: directed scenarios plus a
// randomized phase checked against a round-robin / product reference model.
module tb_mult32x32_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req;
    logic [N-1:0][31:0]  req_a;
    logic [N-1:0][31:0]  req_b;
    logic [N-1:0]        grant;
    logic [N-1:0]        done;
    logic [63:0]         result;
    logic                err;
    logic                mult_start;
    logic [31:0]         mult_a;
    logic [31:0]         mult_b;
    logic                mult_busy;
    logic [63:0]         mult_product;

    int n_checks = 0;
    int n_fail   = 0;

    // multiplier model controls
    logic        dead = 1'b0;
    int unsigned lat  = 3;
    int unsigned mcnt;

    always #5 clk = ~clk;

    mult32x32_arbiter #(
        .N_REQ       (N),
        .ARM_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .grant        (grant),
        .done         (done),
        .result       (result),
        .err          (err),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product)
    );

    // Behavioural multiplier: busy rises the edge after start, stays for lat cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_busy    <= 1'b0;
            mult_product <= '0;
            mcnt         <= 0;
        end else if (mult_start && !dead) begin
            mult_busy    <= 1'b1;
            mcnt         <= lat;
            mult_product <= {32'b0, mult_a} * {32'b0, mult_b};
        end else if (mult_busy) begin
            if (mcnt <= 1) mult_busy <= 1'b0;
            else           mcnt      <= mcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse/one-hot properties, checked every cycle outside reset.
    logic [N-1:0] prev_g = '0, prev_d = '0;
    logic         prev_s = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("grant_onehot", 64'($onehot0(grant)), 64'd1);
            check("done_onehot",  64'($onehot0(done)),  64'd1);
            check("grant_pulse",  64'(grant & prev_g),  64'd0);
            check("done_pulse",   64'(done & prev_d),   64'd0);
            check("start_pulse",  64'(mult_start & prev_s), 64'd0);
            prev_g = grant;
            prev_d = done;
            prev_s = mult_start;
        end else begin
            prev_g = '0;
            prev_d = '0;
            prev_s = 1'b0;
        end
    end

    task automatic wait_grant(input int idx, input string tag);
        int n = 0;
        while (grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(grant), 64'd1 << idx);
    endtask

    task automatic wait_done(input int idx, input logic [63:0] exp, input string tag);
        int n = 0;
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'd1 << idx);
        check({tag, "_result"}, result, exp);
        req[idx] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic int rr_expect(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic run_random(input int ops);
        int          served = 0;
        int          budget = 0;
        int          ptr_m  = 0;
        int          e;
        logic [63:0] exp_prod [N];
        int          cool [N];
        for (int i = 0; i < N; i++) begin
            cool[i]     = 0;
            exp_prod[i] = '0;
        end
        while (served < ops && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (grant != '0) begin
                e = rr_expect(req, ptr_m);
                check("rr_grant", 64'(grant), (e < 0) ? 64'd0 : (64'd1 << e));
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) begin
                        exp_prod[i] = 64'(req_a[i]) * 64'(req_b[i]);
                        req_a[i]    = $urandom;
                        req_b[i]    = $urandom;
                    end
                end
            end
            if (done != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (done[i]) begin
                        check("rand_result", result, exp_prod[i]);
                        req[i]  = 1'b0;
                        cool[i] = 3;
                        ptr_m   = (i + 1) % N;
                        served++;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_a[i] = $urandom;
                    req_b[i] = $urandom;
                    req[i]   = 1'b1;
                end
            end
            lat = $urandom_range(1, 6);
        end
        check("rand_served", 64'(served), 64'(ops));
    endtask

    int stale;

    initial begin
        reset = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_grant",  64'(grant),      64'd0);
        check("rst_done",   64'(done),       64'd0);
        check("rst_result", result,          64'd0);
        check("rst_err",    64'(err),        64'd0);
        check("rst_start",  64'(mult_start), 64'd0);
        check("rst_a",      64'(mult_a),     64'd0);
        check("rst_b",      64'(mult_b),     64'd0);
        reset = 1'b1;
        @(negedge clk);

        // single request
        req_a[0] = 32'd23;
        req_b[0] = 32'd45;
        req[0]   = 1'b1;
        wait_grant(0, "single_grant");
        @(negedge clk);
        check("single_start", 64'(mult_start), 64'd1);
        check("single_grant_gone", 64'(grant), 64'd0);
        wait_done(0, 64'h40B, "single");

        // simultaneous requests after reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_a[i] = 32'(i + 2);
            req_b[i] = 32'd3;
        end
        req = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            wait_grant(i, "simul_grant");
            wait_done(i, 64'(3 * (i + 2)), "simul");
        end

        // wrap-around: serve 3, then 0 and 3 together -> 0 first
        req_a[3] = 32'd10; req_b[3] = 32'd11; req[3] = 1'b1;
        wait_grant(3, "wrap_grant3");
        wait_done(3, 64'd110, "wrap3");
        req_a[0] = 32'd4; req_b[0] = 32'd5;
        req_a[3] = 32'd6; req_b[3] = 32'd7;
        req[0] = 1'b1; req[3] = 1'b1;
        wait_grant(0, "wrap_grant0");
        wait_done(0, 64'd20, "wrap0");
        wait_grant(3, "wrap_grant3b");
        wait_done(3, 64'd42, "wrap3b");

        // operands change right after grant
        req_a[1] = 32'hFFFF_FFFF;
        req_b[1] = 32'hFFFF_FFFF;
        req[1]   = 1'b1;
        wait_grant(1, "opchg_grant");
        req_a[1] = 32'd0;
        req_b[1] = 32'd0;
        wait_done(1, 64'hFFFF_FFFE_0000_0001, "opchg");

        // reset while multiplier is running
        lat = 20;
        req_a[2] = 32'd7; req_b[2] = 32'd9; req[2] = 1'b1;
        wait_grant(2, "midrst_grant");
        repeat (6) @(negedge clk);
        check("midrst_busy", 64'(mult_busy), 64'd1);
        reset = 1'b0;
        req   = '0;
        #1;
        check("midrst_grant0",  64'(grant),      64'd0);
        check("midrst_done0",   64'(done),       64'd0);
        check("midrst_result0", result,          64'd0);
        check("midrst_start0",  64'(mult_start), 64'd0);
        check("midrst_a0",      64'(mult_a),     64'd0);
        check("midrst_b0",      64'(mult_b),     64'd0);
        @(negedge clk);
        reset = 1'b1;
        lat   = 3;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (done != '0) stale++;
        end
        check("midrst_no_stale_done", 64'(stale), 64'd0);
        req_a[2] = 32'd5; req_b[2] = 32'd6; req[2] = 1'b1;
        wait_grant(2, "midrst_new_grant");
        wait_done(2, 64'd30, "midrst_new");

        // arm timeout
        dead = 1'b1;
        req_a[0] = 32'd3; req_b[0] = 32'd4; req[0] = 1'b1;
        wait_grant(0, "to_grant");
        check("to_err_before", 64'(err), 64'd0);
        wait_done(0, 64'd0, "to");
        check("to_err", 64'(err), 64'd1);
        dead = 1'b0;
        req_a[1] = 32'd6; req_b[1] = 32'd7; req[1] = 1'b1;
        wait_grant(1, "to_after_grant");
        wait_done(1, 64'd42, "to_after");
        check("to_err_sticky", 64'(err), 64'd1);
        do_reset();
        check("to_err_cleared", 64'(err), 64'd0);

        // randomized traffic
        run_random(150);
        req = '0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
